// File: rtl/clock_div_monitor.sv
// clock_div_monitor: measures the period of an asynchronous divided clock in
// clk cycles, tracks lock against the expected divide ratio and reports
// frequency errors, missing edges and unconsumed-period overruns as sticky flags.
module clock_div_monitor #(
    parameter int NUM_STAGES = 7,
    parameter int TOLERANCE  = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 4 * (2 ** NUM_STAGES),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clk_div_in,
    input  logic                 period_ready,
    input  logic                 clear_error,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 freq_error,
    output logic                 timeout,
    output logic                 overrun
);

    localparam int EXPECTED = 2 ** NUM_STAGES;
    localparam int EXP_LO   = (EXPECTED > TOLERANCE) ? (EXPECTED - TOLERANCE) : 0;
    localparam int EXP_HI   = EXPECTED + TOLERANCE;
    localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] EXP_LO_C  = CNT_WIDTH'(EXP_LO);
    localparam logic [CNT_WIDTH-1:0] EXP_HI_C  = CNT_WIDTH'(EXP_HI);
    localparam logic [GOOD_W-1:0]    GOOD_ZERO = {GOOD_W{1'b0}};
    localparam logic [GOOD_W-1:0]    GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0]    LOCK_C    = GOOD_W'(LOCK_COUNT);

    // The counter must be able to reach the timeout value, otherwise a stalled
    // input could never be reported.
    if (((64'd1 << CNT_WIDTH) - 64'd1) < 64'(TIMEOUT)) begin : g_cnt_width_too_small
        $error("clock_div_monitor: CNT_WIDTH too narrow for TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic                  sync1_r;
    logic                  sync2_r;
    logic                  sync3_r;
    logic                  rise_s;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_nx_s;
    logic [GOOD_W-1:0]     good_r;
    logic [GOOD_W-1:0]     good_nx_s;
    logic [GOOD_W-1:0]     good_inc_s;
    logic                  in_tol_s;
    logic                  capture_s;
    logic                  freq_set_s;
    logic                  timeout_set_s;
    logic                  overrun_set_s;
    logic [CNT_WIDTH-1:0]  period_nx_s;
    logic                  period_valid_nx_s;
    logic                  locked_nx_s;
    logic                  freq_error_nx_s;
    logic                  timeout_nx_s;
    logic                  overrun_nx_s;

    assign rise_s     = sync2_r & ~sync3_r;
    assign in_tol_s   = (cnt_r >= EXP_LO_C) && (cnt_r <= EXP_HI_C);
    assign good_inc_s = (good_r == LOCK_C) ? LOCK_C : (good_r + GOOD_ONE);

    // Two-flop synchronizer for the asynchronous input plus one history flop for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= clk_div_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Next-state, counter, lock tracking, handshake and sticky-flag logic
    always_comb begin
        state_nx_s        = state_r;
        cnt_nx_s          = cnt_r;
        good_nx_s         = good_r;
        locked_nx_s       = locked;
        period_nx_s       = period;
        period_valid_nx_s = period_valid;
        freq_error_nx_s   = freq_error;
        timeout_nx_s      = timeout;
        overrun_nx_s      = overrun;
        capture_s         = 1'b0;
        freq_set_s        = 1'b0;
        timeout_set_s     = 1'b0;
        overrun_set_s     = 1'b0;

        if (!enable) begin
            // Disabling drops the measurement but keeps the reported results.
            state_nx_s  = IDLE;
            cnt_nx_s    = CNT_ZERO;
            good_nx_s   = GOOD_ZERO;
            locked_nx_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s = SYNC;
                    cnt_nx_s   = CNT_ZERO;
                end
                SYNC: begin
                    // First rise only opens a period; nothing to capture yet.
                    if (rise_s) begin
                        state_nx_s = MEASURE;
                        cnt_nx_s   = CNT_ONE;
                    end else begin
                        state_nx_s = SYNC;
                        cnt_nx_s   = CNT_ZERO;
                    end
                end
                MEASURE: begin
                    if (rise_s) begin
                        capture_s = 1'b1;
                        cnt_nx_s  = CNT_ONE;
                        if (in_tol_s) begin
                            good_nx_s   = good_inc_s;
                            locked_nx_s = (good_inc_s == LOCK_C);
                        end else begin
                            good_nx_s   = GOOD_ZERO;
                            locked_nx_s = 1'b0;
                            freq_set_s  = 1'b1;
                        end
                    end else if (cnt_r == TIMEOUT_C) begin
                        // Input stalled: resynchronise on the next edge.
                        state_nx_s    = SYNC;
                        cnt_nx_s      = CNT_ZERO;
                        good_nx_s     = GOOD_ZERO;
                        locked_nx_s   = 1'b0;
                        timeout_set_s = 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
                default: begin
                    state_nx_s  = IDLE;
                    cnt_nx_s    = CNT_ZERO;
                    good_nx_s   = GOOD_ZERO;
                    locked_nx_s = 1'b0;
                end
            endcase

            // A capture always loads the new value; it only counts as an overrun
            // if the previous value is neither consumed now nor earlier.
            overrun_set_s = capture_s & period_valid & ~period_ready;
            if (capture_s) begin
                period_nx_s       = cnt_r;
                period_valid_nx_s = 1'b1;
            end else if (period_valid && period_ready) begin
                period_valid_nx_s = 1'b0;
            end else begin
                period_valid_nx_s = period_valid;
            end

            // Sticky flags: a set event in the same cycle beats clear_error.
            if (freq_set_s) begin
                freq_error_nx_s = 1'b1;
            end else if (clear_error) begin
                freq_error_nx_s = 1'b0;
            end else begin
                freq_error_nx_s = freq_error;
            end
            if (timeout_set_s) begin
                timeout_nx_s = 1'b1;
            end else if (clear_error) begin
                timeout_nx_s = 1'b0;
            end else begin
                timeout_nx_s = timeout;
            end
            if (overrun_set_s) begin
                overrun_nx_s = 1'b1;
            end else if (clear_error) begin
                overrun_nx_s = 1'b0;
            end else begin
                overrun_nx_s = overrun;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Measurement datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= CNT_ZERO;
            good_r       <= GOOD_ZERO;
            period       <= CNT_ZERO;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            freq_error   <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            cnt_r        <= cnt_nx_s;
            good_r       <= good_nx_s;
            period       <= period_nx_s;
            period_valid <= period_valid_nx_s;
            locked       <= locked_nx_s;
            freq_error   <= freq_error_nx_s;
            timeout      <= timeout_nx_s;
            overrun      <= overrun_nx_s;
        end
    end

endmodule

// File: doc/clock_div_monitor.md
CLOCK_DIV_MONITOR -- requirements
Module: clock_div_monitor

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 7: divider stage count; expected period EXPECTED = 2^NUM_STAGES clk cycles.
REQ-002 SHALL have parameter TOLERANCE, default 2: allowed |period - EXPECTED| in cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive in-tolerance periods required to assert locked.
REQ-004 SHALL have parameter TIMEOUT, default 4*2^NUM_STAGES: cycles without a rising edge before timeout.
REQ-005 SHALL have parameter CNT_WIDTH, default 16: width of counter and period; SHALL satisfy 2^CNT_WIDTH-1 >= TIMEOUT, else elaboration error.
REQ-006 SHALL have port clk, input, 1: single clock; all logic posedge clk.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port enable, input, 1: monitor enable.
REQ-009 SHALL have port clk_div_in, input, 1: divided clock under test, asynchronous to clk.
REQ-010 SHALL have port period_ready, input, 1: consumer accepts period.
REQ-011 SHALL have port clear_error, input, 1: clears sticky flags.
REQ-012 SHALL have port period, output, CNT_WIDTH: last measured period in clk cycles.
REQ-013 SHALL have port period_valid, output, 1: period holds unconsumed data.
REQ-014 SHALL have ports locked, freq_error, timeout and overrun: outputs, 1 bit each.

Function
REQ-015 SHALL pass clk_div_in through a 2-flop synchronizer plus one history flop; rise = sync2 & ~sync3 (3-cycle input-to-rise latency).
REQ-016 SHALL implement FSM states IDLE, SYNC and MEASURE.
REQ-017 IDLE: enable=1 -> SYNC next cycle.
REQ-018 SYNC: rise -> MEASURE, cnt <= 1, no capture.
REQ-019 MEASURE: non-rise cycle -> cnt increments, saturating at 2^CNT_WIDTH-1; rise -> period <= cnt, period_valid <= 1, cnt <= 1.
REQ-020 SHALL drive the FSM to IDLE on the next cycle in any state when enable=0, clearing cnt, locked and the good-period count.
REQ-021 SHALL keep period, period_valid and sticky flags unchanged on enable=0.
REQ-022 MEASURE with cnt = TIMEOUT and no rise -> timeout <= 1, locked <= 0, good count <= 0, state SYNC.
REQ-023 SHALL classify a captured period as good iff EXPECTED-TOLERANCE <= period <= EXPECTED+TOLERANCE, unsigned compare.
REQ-024 Good period: good count increments, saturating at LOCK_COUNT; locked <= 1 once the count reaches LOCK_COUNT, same cycle as the capture.
REQ-025 Bad period: good count <= 0, locked <= 0, freq_error <= 1.
REQ-026 SHALL clear period_valid on period_valid & period_ready.
REQ-027 Capture while period_valid=1 and period_ready=0: SHALL overwrite period and set overrun <= 1.
REQ-028 Capture coincident with acceptance: SHALL load the new value, keep period_valid=1 and leave overrun unset.
REQ-029 SHALL hold period stable while period_valid=1 and no capture occurs.
REQ-030 clear_error SHALL clear freq_error, timeout and overrun; a set event in the same cycle wins.

Reset
REQ-031 rst=1 SHALL force state IDLE, synchronizer flops 0, cnt 0, good count 0, period 0, and period_valid, locked, freq_error, timeout and overrun all 0, on the next clk edge.
REQ-032 rst SHALL take priority over enable, clear_error and all capture events.
REQ-033 rst asserted mid-measurement SHALL discard the partial count; the first rise after release re-enters MEASURE with no capture.

Verification
REQ-034 enable=1, ideal divide-by-128 clk_div_in, period_ready=1 -> first capture period=128 one edge after the first post-SYNC rise; locked=1 at the 4th capture; freq_error=0.
REQ-035 After lock, a single period of 131 -> freq_error=1, locked=0; locked returns after 4 further 128-cycle periods; clear_error pulse -> freq_error=0.
REQ-036 After lock, hold clk_div_in low 600 cycles -> timeout=1 at cnt=512, locked=0, state SYNC; the next rise produces no capture.
REQ-037 period_ready=0 across two captures -> period_valid=1, period=latest value, overrun=1; period_ready=1 with a coincident capture -> valid stays 1, overrun unchanged.
REQ-038 rst pulse mid-period and enable toggled low -> all outputs match REQ-031 (rst) or hold per REQ-021 (enable); FSM in IDLE.
REQ-039 clear_error and a bad-period capture in the same cycle -> freq_error=1.
